// File: rtl/hf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hf_pkg                                                  |
// | Purpose  : Shared defaults and FSM encoding for the Huffman encoder|
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package hf_pkg;

   localparam int c_sym_w_def   = 4;
   localparam int c_max_len_def = 16;
   localparam int c_out_w_def   = 8;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      EMIT  = 2'd1,
      FLUSH = 2'd2
   } hf_state_e;

endpackage
`default_nettype wire

// File: rtl/hf_code_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hf_code_table                                           |
// | Purpose  : {len, code} table, sync write port, combinational read  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module hf_code_table
   import hf_pkg::*;
#(
   parameter int SYM_W   = c_sym_w_def,
   parameter int MAX_LEN = c_max_len_def,
   parameter int LEN_W   = $clog2(c_max_len_def + 1)
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               we,
   input  logic [SYM_W-1:0]   wr_sym,
   input  logic [MAX_LEN-1:0] wr_code,
   input  logic [LEN_W-1:0]   wr_len,
   input  logic [SYM_W-1:0]   rd_sym,
   output logic [MAX_LEN-1:0] rd_code,
   output logic [LEN_W-1:0]   rd_len
);

   localparam int c_depth = 2 ** SYM_W;

   logic [MAX_LEN-1:0] r_code [c_depth];
   logic [LEN_W-1:0]   r_len  [c_depth];

   for (genvar g = 0; g < c_depth; g++) begin : g_entry
      always_ff @(posedge CLK or posedge Reset) begin
         if (Reset) begin
            r_code[g] <= '0;
            r_len[g]  <= '0;
         end else if (we && (wr_sym == SYM_W'(g))) begin
            r_code[g] <= wr_code;
            r_len[g]  <= wr_len;
         end
      end
   end

   assign rd_code = r_code[rd_sym];
   assign rd_len  = r_len[rd_sym];

endmodule
`default_nettype wire

// File: rtl/hf_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : hf_encoder                                              |
// | Purpose  : Serial symbol in, table-driven Huffman code bits packed |
// |            into OUT_W-bit words out                                |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module hf_encoder
   import hf_pkg::*;
#(
   parameter int SYM_W   = c_sym_w_def,
   parameter int MAX_LEN = c_max_len_def,
   parameter int OUT_W   = c_out_w_def
) (
   input  logic                          CLK,
   input  logic                          Reset,
   input  logic                          in_valid,
   input  logic                          val_in,
   output logic                          in_ready,
   input  logic                          flush,
   input  logic                          tbl_we,
   input  logic [SYM_W-1:0]              tbl_sym,
   input  logic [MAX_LEN-1:0]            tbl_code,
   input  logic [$clog2(MAX_LEN+1)-1:0]  tbl_len,
   output logic [OUT_W-1:0]              hf_c,
   output logic                          hf_c_valid,
   output logic [$clog2(OUT_W+1)-1:0]    hf_c_nbits,
   output logic                          err
);

   localparam int c_len_w = $clog2(MAX_LEN + 1);
   localparam int c_nb_w  = $clog2(OUT_W + 1);
   localparam int c_cnt_w = $clog2(SYM_W + 1);

   hf_state_e            r_state;
   logic [SYM_W-2:0]     r_acc;
   logic [c_cnt_w-1:0]   r_bcnt;
   logic [MAX_LEN-1:0]   r_emit_code;
   logic [c_len_w-1:0]   r_emit_rem;
   logic [OUT_W-1:0]     r_pack;
   logic [c_nb_w-1:0]    r_pcnt;
   logic                 r_flush_pend;
   logic                 r_err;
   logic [OUT_W-1:0]     r_hf_c;
   logic                 r_hf_c_valid;
   logic [c_nb_w-1:0]    r_hf_c_nbits;

   logic                 w_accept;
   logic                 w_last_bit;
   logic [SYM_W-1:0]     w_sym;
   logic [MAX_LEN-1:0]   w_lk_code;
   logic [c_len_w-1:0]   w_lk_len;
   logic [MAX_LEN-1:0]   w_lk_aligned;
   logic                 w_emit_bit;
   logic [OUT_W-1:0]     w_pack_ins;

   assign in_ready   = (r_state == ACCUM) && !Reset;
   assign w_accept   = in_valid && in_ready;
   assign w_last_bit = w_accept && (r_bcnt == c_cnt_w'(SYM_W - 1));
   // The final bit completes the symbol combinationally, so only SYM_W-1 bits are stored.
   assign w_sym      = {r_acc, val_in};

   hf_code_table #(
      .SYM_W   (SYM_W),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (c_len_w)
   ) u_table (
      .CLK     (CLK),
      .Reset   (Reset),
      .we      (tbl_we),
      .wr_sym  (tbl_sym),
      .wr_code (tbl_code),
      .wr_len  (tbl_len),
      .rd_sym  (w_sym),
      .rd_code (w_lk_code),
      .rd_len  (w_lk_len)
   );

   // Codes are left-aligned at latch time so EMIT always takes the MSB.
   assign w_lk_aligned = w_lk_code << (c_len_w'(MAX_LEN) - w_lk_len);
   assign w_emit_bit   = r_emit_code[MAX_LEN-1];
   assign w_pack_ins   = r_pack | ({w_emit_bit, {(OUT_W-1){1'b0}}} >> r_pcnt);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state      <= ACCUM;
         r_acc        <= '0;
         r_bcnt       <= '0;
         r_emit_code  <= '0;
         r_emit_rem   <= '0;
         r_pack       <= '0;
         r_pcnt       <= '0;
         r_flush_pend <= 1'b0;
         r_err        <= 1'b0;
         r_hf_c       <= '0;
         r_hf_c_valid <= 1'b0;
         r_hf_c_nbits <= '0;
      end else begin
         r_hf_c_valid <= 1'b0;
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  r_acc  <= w_sym[SYM_W-2:0];
                  r_bcnt <= w_last_bit ? '0 : r_bcnt + c_cnt_w'(1);
               end
               if (w_last_bit) begin
                  if (w_lk_len == '0) begin
                     r_err <= 1'b1;
                  end else begin
                     r_emit_code <= w_lk_aligned;
                     r_emit_rem  <= w_lk_len;
                     r_state     <= EMIT;
                  end
                  if (flush) r_flush_pend <= 1'b1;
               end else if (flush || r_flush_pend) begin
                  r_flush_pend <= 1'b0;
                  if (r_pcnt != '0) r_state <= FLUSH;
               end
            end
            EMIT: begin
               if (flush) r_flush_pend <= 1'b1;
               r_emit_code <= r_emit_code << 1;
               r_emit_rem  <= r_emit_rem - c_len_w'(1);
               if (r_pcnt == c_nb_w'(OUT_W - 1)) begin
                  r_hf_c       <= w_pack_ins;
                  r_hf_c_valid <= 1'b1;
                  r_hf_c_nbits <= c_nb_w'(OUT_W);
                  r_pack       <= '0;
                  r_pcnt       <= '0;
               end else begin
                  r_pack <= w_pack_ins;
                  r_pcnt <= r_pcnt + c_nb_w'(1);
               end
               if (r_emit_rem == c_len_w'(1)) r_state <= ACCUM;
            end
            FLUSH: begin
               if (flush) r_flush_pend <= 1'b1;
               r_hf_c       <= r_pack;
               r_hf_c_valid <= 1'b1;
               r_hf_c_nbits <= r_pcnt;
               r_pack       <= '0;
               r_pcnt       <= '0;
               r_state      <= ACCUM;
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   assign hf_c       = r_hf_c;
   assign hf_c_valid = r_hf_c_valid;
   assign hf_c_nbits = r_hf_c_nbits;
   assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hf_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_hf_encoder                                           |
// | Purpose  : Directed scoreboard bench for hf_encoder                |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_hf_encoder;

   typedef struct packed {
      logic [7:0] c;
      logic [3:0] nb;
   } pulse_t;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        in_valid;
   logic        val_in;
   logic        in_ready;
   logic        flush;
   logic        tbl_we;
   logic [3:0]  tbl_sym;
   logic [15:0] tbl_code;
   logic [4:0]  tbl_len;
   logic [7:0]  hf_c;
   logic        hf_c_valid;
   logic [3:0]  hf_c_nbits;
   logic        err;

   int     checks = 0;
   int     errors = 0;
   pulse_t exp_q[$];

   hf_encoder #(.SYM_W(4), .MAX_LEN(16), .OUT_W(8)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .in_valid   (in_valid),
      .val_in     (val_in),
      .in_ready   (in_ready),
      .flush      (flush),
      .tbl_we     (tbl_we),
      .tbl_sym    (tbl_sym),
      .tbl_code   (tbl_code),
      .tbl_len    (tbl_len),
      .hf_c       (hf_c),
      .hf_c_valid (hf_c_valid),
      .hf_c_nbits (hf_c_nbits),
      .err        (err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every clock advance goes through here, so no output pulse is missed.
   task automatic tick();
      pulse_t e;
      @(posedge CLK);
      #1;
      if (hf_c_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_pulse observed=%0h/%0d expected=none", hf_c, hf_c_nbits);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_data", 32'(hf_c), 32'(e.c));
            chk("pulse_nbits", 32'(hf_c_nbits), 32'(e.nb));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic tbl_write(input logic [3:0] s, input logic [15:0] c, input logic [4:0] l);
      tbl_sym = s; tbl_code = c; tbl_len = l; tbl_we = 1'b1;
      tick();
      tbl_we = 1'b0;
   endtask

   task automatic send_bits(input logic [3:0] sym);
      int n;
      for (int i = 3; i >= 0; i--) begin
         n = 0;
         while (!in_ready && n < 200) begin tick(); n++; end
         chk("in_ready_wait", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         val_in   = sym[i];
         tick();
         in_valid = 1'b0;
      end
   endtask

   // Returns the number of cycles in_ready stays low after the symbol completes.
   task automatic send_sym(input logic [3:0] sym, input int flush_at, input int wr_at,
                           output int low);
      send_bits(sym);
      low = 0;
      while (!in_ready && low < 100) begin
         flush  = (low == flush_at);
         tbl_we = (low == wr_at);
         tick();
         flush  = 1'b0;
         tbl_we = 1'b0;
         low++;
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle(4);
   endtask

   initial begin
      int low;
      Reset = 1'b1; in_valid = 1'b0; val_in = 1'b0; flush = 1'b0;
      tbl_we = 1'b0; tbl_sym = '0; tbl_code = '0; tbl_len = '0;
      idle(2);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_hf_c", 32'(hf_c), 32'd0);
      chk("rst_valid", 32'(hf_c_valid), 32'd0);
      chk("rst_nbits", 32'(hf_c_nbits), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      Reset = 1'b0;
      #1;
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      tbl_write(4'h3, 16'b10, 5'd2);
      tbl_write(4'h5, 16'b011, 5'd3);

      // 0x3,0x5,0x3 -> 7 bits held, then flush drains them
      send_sym(4'h3, -1, -1, low);
      send_sym(4'h5, -1, -1, low);
      send_sym(4'h3, -1, -1, low);
      idle(3);
      chk("no_pulse_7bits", 32'(exp_q.size()), 32'd0);
      exp_q.push_back('{c: 8'b10011100, nb: 4'd7});
      do_flush();
      chk("flush7_drained", 32'(exp_q.size()), 32'd0);
      idle(3);
      chk("hold_hf_c", 32'(hf_c), 32'h9C);
      chk("hold_nbits", 32'(hf_c_nbits), 32'd7);

      // four 0x3 symbols fill exactly one word
      exp_q.push_back('{c: 8'hAA, nb: 4'd8});
      for (int k = 0; k < 4; k++) begin
         send_sym(4'h3, -1, -1, low);
         chk("len2_busy_cycles", 32'(low), 32'd2);
      end
      idle(2);
      chk("aa_drained", 32'(exp_q.size()), 32'd0);

      // maximum-length code spans two output words
      tbl_write(4'hF, 16'hFFFF, 5'd16);
      exp_q.push_back('{c: 8'hFF, nb: 4'd8});
      exp_q.push_back('{c: 8'hFF, nb: 4'd8});
      send_sym(4'hF, -1, -1, low);
      chk("len16_busy_cycles", 32'(low), 32'd16);
      idle(2);
      chk("ff_drained", 32'(exp_q.size()), 32'd0);

      // flush during EMIT is serviced after the symbol completes
      exp_q.push_back('{c: 8'b01100000, nb: 4'd3});
      send_sym(4'h5, 1, -1, low);
      chk("len3_busy_cycles", 32'(low), 32'd3);
      idle(4);
      chk("midemit_flush_drained", 32'(exp_q.size()), 32'd0);

      // rewrite 0x5 during its own emission
      tbl_sym = 4'h5; tbl_code = 16'b1101; tbl_len = 5'd4;
      exp_q.push_back('{c: 8'b01111011, nb: 4'd8});
      send_sym(4'h5, -1, 1, low);
      chk("old_code_len", 32'(low), 32'd3);
      send_sym(4'h5, -1, -1, low);
      chk("new_code_len", 32'(low), 32'd4);
      send_sym(4'h3, -1, -1, low);
      idle(2);
      exp_q.push_back('{c: 8'h00, nb: 4'd1});
      do_flush();
      chk("rewrite_drained", 32'(exp_q.size()), 32'd0);

      // unused symbol: no bits, err sticky, no stall
      chk("err_before", 32'(err), 32'd0);
      send_sym(4'h7, -1, -1, low);
      chk("unused_busy_cycles", 32'(low), 32'd0);
      chk("err_set", 32'(err), 32'd1);
      do_flush();
      exp_q.push_back('{c: 8'b10000000, nb: 4'd2});
      send_sym(4'h3, -1, -1, low);
      do_flush();
      chk("unused_no_bits", 32'(exp_q.size()), 32'd0);
      chk("err_sticky", 32'(err), 32'd1);

      // reset in the middle of a long emission
      send_bits(4'hF);
      idle(5);
      Reset = 1'b1;
      #1;
      chk("midrst_hf_c", 32'(hf_c), 32'd0);
      chk("midrst_nbits", 32'(hf_c_nbits), 32'd0);
      chk("midrst_valid", 32'(hf_c_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      tick();
      Reset = 1'b0;
      #1;
      send_sym(4'h3, -1, -1, low);
      chk("tbl_cleared_busy", 32'(low), 32'd0);
      chk("tbl_cleared_err", 32'(err), 32'd1);
      do_flush();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
